cla4_serial_adder: RTL and testbench
====================================

Name: cla4_serial_adder

Overview:
Nibble-serial wide adder that drives one internal cla4 (4-bit carry-lookahead adder) instance over multiple cycles. It accepts WIDTH-bit operands through a valid/ready handshake and feeds one nibble per cycle into cla4, least-significant first. The cla4 carry-out is registered and becomes the carry-in for the next nibble. The assembled WIDTH-bit sum and final carry are presented through an output valid/ready handshake. The block is used wherever a wide add is needed but one small adder is preferred over a wide one.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NIB (derived, not overridable), WIDTH/4, number of nibble steps per operation

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  operands a, b, cin valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into nibble 0
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, low WIDTH bits
cout  output  1  carry out of the top nibble

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n low at a rising edge): state = IDLE, nibble counter = 0, carry register = 0, operand registers = 0, sum = 0, cout = 0, out_valid = 0.
- Reset mid-RUN or in DONE aborts the operation with no output. in_ready is 0 while rst_n is low.
- in_ready = (state == IDLE) && rst_n. It is a combinational function of state only, with no dependency on in_valid.
- IDLE: on in_valid && in_ready:
  - latch a, b into the operand shift registers and cin into the carry register;
  - clear the counter;
  - go to RUN.
  - Any other in_valid is ignored.
- RUN, one nibble per cycle:
  - cla4 inputs are the low nibble of each operand register plus the carry register.
  - At the edge: the cla4 sum nibble enters sum_reg from the top, and sum_reg shifts right by 4.
  - Both operand registers shift right by 4.
  - The carry register takes the cla4 cout.
  - The counter increments.
  - On the edge that processes nibble NIB-1: cout is set to the cla4 cout, state goes to DONE, and out_valid goes to 1.
- Latency: out_valid rises exactly NIB rising edges after the accepting edge. For WIDTH=16, out_valid is high in the 4th cycle after the accept edge.
- DONE:
  - sum and cout are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: state goes to IDLE and out_valid goes to 0. sum and cout keep their last value.
  - in_valid is not accepted in the same cycle; throughput is one operation per NIB+2 cycles minimum.
- Arithmetic: {cout, sum} = a + b + cin, exact (WIDTH+1)-bit result. The carry ripples between nibbles only through the carry register.
- WIDTH=4: a single RUN cycle; out_valid one edge after accept.
- in_valid, a, b and cin are don't-care outside IDLE. Operands are captured only at the accept edge; later changes to a or b have no effect.
- out_ready is don't-care when out_valid = 0.
- sum and cout are registered outputs, with no combinational path from the inputs.

Test Plan:
- Reset then idle, WIDTH=16 -> in_ready=1, out_valid=0, sum=0x0000, cout=0; while rst_n=0, in_ready=0.
- a=0x1234, b=0x4321, cin=0, out_ready=1 -> sum=0x5555, cout=0, out_valid high exactly 4 edges after accept, one cycle only, then in_ready=1.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, exercising carry propagation through all 4 nibbles.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Also a=0x8000, b=0x8000, cin=1 -> sum=0x0001, cout=1.
- Backpressure: after a result, hold out_ready=0 for 5 cycles while toggling in_valid with new operands -> sum/cout/out_valid stable, in_ready=0, no capture. Raise out_ready -> IDLE next edge, then the new operation is accepted.
- Reset mid-RUN: assert rst_n=0 for one edge after nibble 1 -> out_valid never rises, state IDLE. Follow with 0x00FF+0x0F01, cin=0 -> sum=0x1000, cout=0. Finish with 1000 random operations (also WIDTH=4 and WIDTH=32) checked against a+b+cin and the NIB-edge latency.

Source files
------------

// File: rtl/cla4_serial_adder.sv
// Nibble-serial wide adder built around a single 4-bit carry-lookahead adder.
// Operands are consumed least-significant nibble first, one nibble per clock.
// The carry between nibbles passes only through carry_q.

// 4-bit carry-lookahead adder with all carries expanded from generate/propagate.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g, p;
    logic       c1, c2, c3;

    assign g  = a & b;
    assign p  = a ^ b;
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s  = p ^ {c3, c2, c1, ci};
endmodule

module cla4_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("cla4_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       nib_s;
    logic             nib_co;

    cla4 u_cla4 (
        .a  (a_q[3:0]),
        .b  (b_q[3:0]),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    // Accept only in IDLE and never while reset is held, independent of in_valid.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

    // Next-state: capture on accept, shift one nibble per RUN cycle, release on out_ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                sum_d   = (sum_q >> 4) | (WIDTH'(nib_s) << (WIDTH - 4));
                carry_d = nib_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NIB - 1)) begin
                    cout_d      = nib_co;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_cla4_serial_adder.sv
// Bench for cla4_serial_adder: directed sequence on WIDTH=16, then random
// operations on WIDTH=4, 16 and 32 instances, with a result scoreboard.
module tb_cla4_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_d, b_d;
    logic        cin_d, out_ready_d;
    logic        iv4, iv16, iv32;
    logic        ir4, ir16, ir32;
    logic        ov4, ov16, ov32;
    logic        c4, c16, c32;
    logic [3:0]  s4;
    logic [15:0] s16;
    logic [31:0] s32;

    int checks = 0;
    int fails  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    cla4_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a_d[3:0]), .b(b_d[3:0]),
        .cin(cin_d), .out_valid(ov4), .out_ready(out_ready_d), .sum(s4), .cout(c4));
    cla4_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a_d[15:0]), .b(b_d[15:0]),
        .cin(cin_d), .out_valid(ov16), .out_ready(out_ready_d), .sum(s16), .cout(c16));
    cla4_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a_d), .b(b_d),
        .cin(cin_d), .out_valid(ov32), .out_ready(out_ready_d), .sum(s32), .cout(c32));

    function automatic int wid(int k);
        return (k == 0) ? 4 : (k == 1) ? 16 : 32;
    endfunction
    function automatic logic get_ov(int k);
        return (k == 0) ? ov4 : (k == 1) ? ov16 : ov32;
    endfunction
    function automatic logic get_ir(int k);
        return (k == 0) ? ir4 : (k == 1) ? ir16 : ir32;
    endfunction
    function automatic logic [63:0] get_res(int k);
        case (k)
            0:       return {59'd0, c4, s4};
            1:       return {47'd0, c16, s16};
            default: return {31'd0, c32, s32};
        endcase
    endfunction
    task automatic set_iv(int k, logic v);
        case (k)
            0:       iv4 = v;
            1:       iv16 = v;
            default: iv32 = v;
        endcase
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one operation on instance k; checks accept, NIB-edge latency and result.
    // If out_ready_d is high the result is consumed and the return to IDLE is checked.
    task automatic do_op(int k, logic [31:0] a, logic [31:0] b, logic cin);
        int w, n;
        logic [63:0] mask, full, exp;
        w    = wid(k);
        mask = (64'd1 << w) - 1;
        a_d  = a & mask[31:0];
        b_d  = b & mask[31:0];
        cin_d = cin;
        full = 64'(a_d) + 64'(b_d) + 64'(cin);
        exp_q.push_back(full & ((64'd1 << (w + 1)) - 1));
        chk("in_ready_before_accept", 64'(get_ir(k)), 64'd1);
        set_iv(k, 1'b1);
        @(posedge clk); #1;
        set_iv(k, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!get_ov(k) && n < w / 4 + 3);
        chk("latency", 64'(n), 64'(w / 4));
        exp = exp_q.pop_front();
        if (get_ov(k)) chk("result", get_res(k), exp);
        if (out_ready_d) begin
            @(posedge clk); #1;
            chk("out_valid_one_cycle", 64'(get_ov(k)), 64'd0);
            chk("in_ready_after", 64'(get_ir(k)), 64'd1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] held;
        rst_n = 1'b0; out_ready_d = 1'b1; cin_d = 1'b0;
        a_d = '0; b_d = '0; iv4 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;

        // Reset behaviour
        #1;
        chk("in_ready_in_reset", 64'(ir16), 64'd0);
        @(posedge clk); #1;
        chk("rst_out_valid", 64'(ov16), 64'd0);
        chk("rst_result", get_res(1), 64'd0);
        chk("in_ready_in_reset2", 64'(ir16), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("in_ready_idle", 64'(ir16), 64'd1);

        // Directed arithmetic
        do_op(1, 32'h1234, 32'h4321, 1'b0);
        do_op(1, 32'hFFFF, 32'h0001, 1'b0);
        do_op(1, 32'hFFFF, 32'h0000, 1'b1);
        do_op(1, 32'h8000, 32'h8000, 1'b1);

        // Backpressure: result held, no capture while DONE
        out_ready_d = 1'b0;
        do_op(1, 32'h1111, 32'h2222, 1'b0);
        held = get_res(1);
        chk("bp_held_value", held, 64'h3333);
        for (int i = 0; i < 5; i++) begin
            iv16 = ~i[0];
            a_d = $urandom; b_d = $urandom; cin_d = i[1];
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(ov16), 64'd1);
            chk("bp_result", get_res(1), held);
            chk("bp_in_ready", 64'(ir16), 64'd0);
        end
        iv16 = 1'b0;
        out_ready_d = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ov", 64'(ov16), 64'd0);
        chk("bp_release_ir", 64'(ir16), 64'd1);
        do_op(1, 32'hABCD, 32'h1234, 1'b1);

        // Reset in the middle of RUN
        a_d = 32'h5555; b_d = 32'h7777; cin_d = 1'b1; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_in_ready_low", 64'(ir16), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrun_cleared", get_res(1), 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("midrun_no_output", 64'(ov16), 64'd0);
            @(posedge clk); #1;
        end
        chk("midrun_idle", 64'(ir16), 64'd1);
        do_op(1, 32'h00FF, 32'h0F01, 1'b0);

        // Random operations on every width
        for (int i = 0; i < 1000; i++) do_op(1, $urandom, $urandom, 1'($urandom));
        for (int i = 0; i < 150; i++) do_op(0, $urandom, $urandom, 1'($urandom));
        for (int i = 0; i < 150; i++) do_op(2, $urandom, $urandom, 1'($urandom));
        do_op(0, 32'hF, 32'hF, 1'b1);
        do_op(2, 32'hFFFF_FFFF, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
